conveyor_belt_model: RTL

//  Behavioural-synthesizable plant model of the assembly-line conveyor: the sensor side of the controller interface.

---
 rtl/conveyor_belt_model.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/conveyor_belt_model.sv
// conveyor_belt_model
//   Plant model of the assembly-line conveyor, i.e. the sensor side of the
//   belt controller. The belt is a row of SLOTS occupancy bits. A piece enters
//   at slot 0 through a load handshake. The belt shifts one slot every STEP_CYC
//   cycles in which the motor is enabled. A piece that steps off slot
//   SLOTS-1 is counted as delivered.
//
//   Optional feature: define STALL_MON_EN to enable the stall monitor. When it
//   is enabled, STALL_LIM consecutive cycles with the motor off and a loaded
//   belt set a sticky stall flag and freeze the state code at STALL.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   z         in   motor enable (1 = belt moving)
//   load      in   piece placement request, held until load_ack
//   load_ack  out  1-cycle pulse per accepted piece
//   x/t/y     out  entry / tool (slot T_POS) / exit sensors, straight from occ
//   done_cnt  out  delivered pieces, wraps modulo 2^CNT_W
//   state     out  00 EMPTY, 01 MOVING, 10 HALTED, 11 STALL
//   stall     out  sticky stall flag (0 unless STALL_MON_EN)
module conveyor_belt_model #(
  parameter int SLOTS     = 8,
  parameter int STEP_CYC  = 4,
  parameter int T_POS     = 3,
  parameter int CNT_W     = 8,
  parameter int STALL_LIM = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             load,
  output logic             load_ack,
  output logic             x,
  output logic             t,
  output logic             y,
  output logic [CNT_W-1:0] done_cnt,
  output logic [1:0]       state,
  output logic             stall
);

  localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

  if (SLOTS < 3 || STEP_CYC < 1 || T_POS <= 0 || T_POS >= SLOTS - 1 ||
      CNT_W < 1 || STALL_LIM < 1) begin : g_bad_param
    $error("conveyor_belt_model: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_MOVING = 2'b01,
    ST_HALTED = 2'b10,
    ST_STALL  = 2'b11
  } st_e;

  st_e              st, st_nxt;
  logic [SLOTS-1:0] occ, occ_nxt;
  logic [SW-1:0]    step_cnt;
  logic             step, acc, stall_hit;

  // A step vacates slot 0 in the same edge, so a load is accepted either
  // into an empty entry slot or into the slot that the step is freeing.
  assign step = z & (step_cnt == STEP_LAST);
  assign acc  = load & (~occ[0] | step);

  always_comb begin
    occ_nxt = step ? {occ[SLOTS-2:0], 1'b0} : occ;
    if (acc) occ_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ      <= '0;
      step_cnt <= '0;
      done_cnt <= '0;
      load_ack <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      load_ack <= acc;
      // The phase counter only holds while the motor is off. It is not
      // cleared, so a stop-start sequence does not lose partial progress.
      if (step)   step_cnt <= '0;
      else if (z) step_cnt <= step_cnt + 1'b1;
      if (step && occ[SLOTS-1]) done_cnt <= done_cnt + 1'b1;
    end
  end

  assign x = occ[0];
  assign t = occ[T_POS];
  assign y = occ[SLOTS-1];

`ifdef STALL_MON_EN
  localparam int CW = $clog2(STALL_LIM + 1);
  logic [CW-1:0] stall_cnt;
  logic          holding;

  assign holding   = ~z & (|occ);
  // This fires on the edge where the counter reaches STALL_LIM.
  assign stall_hit = holding & (stall_cnt == CW'(STALL_LIM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else begin
      if (!holding)                          stall_cnt <= '0;
      else if (stall_cnt != CW'(STALL_LIM))  stall_cnt <= stall_cnt + 1'b1;
      if (stall_hit) stall <= 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign stall     = 1'b0;
`endif

  // FSM: the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_EMPTY;
    else        st <= st_nxt;
  end

  // FSM: next state. It is judged on the occupancy the belt will hold after
  // this edge, so a load with the motor off lands directly in HALTED.
  always_comb begin
    st_nxt = st;
    if (st != ST_STALL) begin
      if (stall_hit)    st_nxt = ST_STALL;
      else if (z)       st_nxt = ST_MOVING;
      else if (|occ_nxt) st_nxt = ST_HALTED;
      else              st_nxt = ST_EMPTY;
    end
  end

  // FSM: output.
  always_comb begin
    state = st;
  end

endmodule
